led_counter_ctrl: RTL
=====================

LED_COUNTER_CTRL -- requirements
Module: led_counter_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive stable samples required by each button debouncer.
REQ-002 Parameter CLEAR_CYCLES, default 2: cycles ctr_reset is held in CLEAR.
REQ-003 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port btn_run  input  1  raw run/stop button, asynchronous to clk.
REQ-006 Port btn_speed  input  1  raw speed-step button, asynchronous to clk.
REQ-007 Port btn_dir  input  1  raw direction-toggle button, asynchronous to clk.
REQ-008 Port led_in  input  8  LED value fed back from the LED counter.
REQ-009 Port SW  output  2  speed select driven to the LED counter.
REQ-010 Port UD  output  1  count direction to the LED counter; 1 = up, 0 = down.
REQ-011 Port ctr_reset  output  1  synchronous reset driven to the LED counter.
REQ-012 Port busy  output  1  high while in RUN.
REQ-013 Port state  output  2  current FSM state encoding.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer, then a debouncer whose level flips after DEB_CYCLES consecutive synchronized samples that differ from it.
REQ-015 A 0->1 debounced transition SHALL produce a one-cycle press pulse; 1->0 transitions produce nothing.
REQ-016 A raw button held high from edge N SHALL produce its press pulse in cycle N+DEB_CYCLES+2 exactly.
REQ-017 The FSM SHALL have states IDLE=2'b00, RUN=2'b01, CLEAR=2'b11; 2'b10 is unused and SHALL transition to IDLE.
REQ-018 IDLE: ctr_reset=1, busy=0; a run press moves to RUN on the next edge.
REQ-019 RUN: ctr_reset=0, busy=1; a run press moves to CLEAR.
REQ-020 CLEAR: ctr_reset=1, busy=0; the FSM stays for exactly CLEAR_CYCLES cycles, then moves to IDLE.
REQ-021 A speed press in IDLE or RUN SHALL increment SW modulo 4 (3 wraps to 0); presses in CLEAR are ignored.
REQ-022 A dir press in IDLE or RUN SHALL toggle UD; presses in CLEAR are ignored.
REQ-023 When a run press coincides with a speed or dir press, the run press SHALL take effect and the others are discarded.
REQ-024 Simultaneous speed and dir presses SHALL both take effect in the same cycle.
REQ-025 SW and UD changes SHALL appear at the outputs one cycle after the press pulse.

Reset
REQ-026 On reset the block SHALL enter IDLE with SW=2'b00, UD=1, ctr_reset=1, busy=0, state=2'b00.
REQ-027 On reset all synchronizers, debounce counters and debounced levels SHALL clear to 0 and the CLEAR counter SHALL clear to 0.
REQ-028 Reset asserted mid-RUN or mid-CLEAR SHALL reach IDLE on the next edge with no press pulse emitted.
REQ-029 A button still held through reset deassertion SHALL register as a fresh press per REQ-016.

Configuration
REQ-030 Macro AUTO_REV_EN defined: in RUN, when UD=1 and led_in==8'hFF, UD SHALL become 0 on the next edge; when UD=0 and led_in==8'h00, UD SHALL become 1.
REQ-031 When a dir press coincides with an auto-reverse condition, the dir press SHALL win and auto-reverse is suppressed for that cycle.
REQ-032 Macro AUTO_REV_EN undefined: UD SHALL change only on dir presses or reset, and led_in SHALL be unused.

Structure
REQ-033 Package led_ctrl_pkg SHALL hold the state encodings, SW_MAX=2'd3 and the default DEB_CYCLES and CLEAR_CYCLES values.
REQ-034 Sub-module btn_debounce (synchronizer, debouncer, press pulse; parameter DEB_CYCLES) SHALL be instantiated three times.

Verification
REQ-035 Reset for 1 cycle -> SW=0, UD=1, ctr_reset=1, busy=0, state=00.
REQ-036 btn_run high from edge 10, DEB_CYCLES=4 -> run pulse at cycle 16; state=01, busy=1, ctr_reset=0 at cycle 17.
REQ-037 In RUN, four separate speed presses -> SW sequence 1,2,3,0.
REQ-038 btn_run and btn_speed rise on the same edge in RUN -> state goes to CLEAR, SW unchanged; ctr_reset=1 for 2 cycles, then IDLE.
REQ-039 AUTO_REV_EN defined, RUN, UD=1, led_in=8'hFF -> UD=0 next cycle; with a dir press on the same cycle -> UD=0 via toggle, no double flip.
REQ-040 btn_dir glitch high for 3 cycles with DEB_CYCLES=4 -> no pulse and UD unchanged; reset asserted mid-CLEAR -> IDLE next edge.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// Shared encodings and defaults for the LED counter controller.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_UNUSED = 2'b10,
        ST_CLEAR  = 2'b11
    } state_e;

    localparam logic [1:0] SW_MAX           = 2'd3;
    localparam int         DEB_CYCLES_DEF   = 4;
    localparam int         CLEAR_CYCLES_DEF = 2;

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop synchronizer -> counting debouncer -> one-cycle press pulse.
module btn_debounce
    import led_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          level_dly_q;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The level flips on the DEB_CYCLES-th consecutive differing sample.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = level_q & ~level_dly_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= btn_raw;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            press_q     <= press_d;
            cnt_q       <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/led_counter_ctrl.sv
// Run/stop, speed and direction control for an external LED counter.
// Optional macro AUTO_REV_EN: reverse direction automatically at the count limits while running.
module led_counter_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
    parameter int CLEAR_CYCLES = CLEAR_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_run,
    input  logic       btn_speed,
    input  logic       btn_dir,
    input  logic [7:0] led_in,
    output logic [1:0] SW,
    output logic       UD,
    output logic       ctr_reset,
    output logic       busy,
    output logic [1:0] state
);

    localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);

    logic             run_p, speed_p, dir_p;
    state_e           state_q, state_d;
    logic [CLR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [1:0]       sw_q, sw_d;
    logic             ud_q, ud_d;
    logic             active;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
        .clk(clk), .reset(reset), .btn_raw(btn_run), .press(run_p));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_speed (
        .clk(clk), .reset(reset), .btn_raw(btn_speed), .press(speed_p));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dir (
        .clk(clk), .reset(reset), .btn_raw(btn_dir), .press(dir_p));

`ifndef AUTO_REV_EN
    logic unused_led;
    assign unused_led = ^led_in;
`endif

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        sw_d      = sw_q;
        ud_d      = ud_q;
        active    = (state_q == ST_IDLE) || (state_q == ST_RUN);

        case (state_q)
            ST_IDLE: begin
                if (run_p) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (run_p) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_q == CLR_W'(CLEAR_CYCLES - 1)) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A run press swallows any speed/dir press landing in the same cycle.
        if (active && !run_p) begin
            if (speed_p) sw_d = (sw_q == SW_MAX) ? 2'd0 : sw_q + 2'd1;
            if (dir_p)   ud_d = ~ud_q;
        end

`ifdef AUTO_REV_EN
        if ((state_q == ST_RUN) && !dir_p) begin
            if (ud_q && (led_in == 8'hFF))       ud_d = 1'b0;
            else if (!ud_q && (led_in == 8'h00)) ud_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            clr_cnt_q <= '0;
            sw_q      <= 2'd0;
            ud_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            sw_q      <= sw_d;
            ud_q      <= ud_d;
        end
    end

    assign SW        = sw_q;
    assign UD        = ud_q;
    assign busy      = (state_q == ST_RUN);
    assign ctr_reset = (state_q != ST_RUN);
    assign state     = state_q;

endmodule
